torus_out_port_arbiter: RTL
===========================

Name: torus_out_port_arbiter

Overview:
- Wormhole round-robin arbiter for one output port of a torus router.
- Shares that output among NUM_IN input FIFOs (N, E, S, W, Local), which have a 1-cycle registered read, empty/full flags and an rd_en input.
- Grants one input per packet, drives that FIFO's rd_en while downstream has space, and releases on the tail flit.
- Generates the mux select and data-valid strobe aligned to the FIFO's 1-cycle read latency.

Parameters:
- NUM_IN, 5, number of input FIFOs competing for this output (2..8).
- SELW, 3, width of the mux select (ceil log2 NUM_IN, min 1).
- MAX_FLITS, 16, maximum flits per packet; reaching it forces release.
- CNTW, 5, width of the per-packet flit counter (holds 0..MAX_FLITS).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-high (port named rst_n, asserted = 1)
- req  in  NUM_IN  req[i]=1: head flit at FIFO i front targets this output
- empty  in  NUM_IN  empty flags of the input FIFOs
- tail  in  NUM_IN  tail[i]=1: flit at FIFO i front is a tail flit
- out_ready  in  1  downstream buffer can accept a flit this cycle (not full)
- rd_en  out  NUM_IN  one-hot/zero read enable to the input FIFOs (combinational)
- grant  out  NUM_IN  registered one-hot owner of the output; 0 when idle
- sel  out  SELW  registered mux select; index of the FIFO whose fifo_out is valid
- out_valid  out  1  registered; fifo_out of FIFO sel holds a new flit this cycle
- busy  out  1  registered; 1 in state BUSY
- overrun  out  1  registered sticky; set when a packet hits MAX_FLITS without a tail

Behaviour:
- Reset (rst_n=1 at posedge):
  - state=IDLE; grant=0; sel=0; out_valid=0; overrun=0; flit counter=0.
  - Round-robin pointer last=NUM_IN-1, so input 0 has first priority.
  - rd_en=0 while in IDLE.
  - Reset mid-packet abandons the packet immediately; there is no drain.
- State IDLE:
  - Eligible set: E = req & ~empty.
  - If E≠0, pick the first set bit searching last+1, last+2, ... with modulo-NUM_IN wrap.
  - Next cycle: grant=that one-hot, state=BUSY, count=0.
  - If E=0, stay in IDLE. No flit is read in IDLE, so grant-to-first-read latency is 1 cycle.
- State BUSY, owner g:
  - rd_en[g] = ~empty[g] & out_ready; all other bits 0.
  - On each cycle with rd_en[g]=1:
    - count increments.
    - Next cycle: out_valid=1, sel=g. Otherwise out_valid=0 next cycle and sel holds.
  - Release when rd_en[g]=1 and (tail[g]=1 or count+1==MAX_FLITS).
    - Next cycle: state=IDLE, grant=0, last=g, count=0.
    - The release cycle's flit still produces out_valid=1 the following cycle.
  - Forced release without tail[g]: overrun<=1, held until reset.
- No grant changes mid-packet: other reqs are ignored while BUSY, and req[g] is don't-care after grant.
- empty[g]=1 or out_ready=0 while BUSY: stall, hold grant, no read, count unchanged.
- Single-flit packet (head also tail): BUSY for exactly one read cycle, then IDLE. The next grant is at least 2 cycles after the previous grant.
- The arbiter never reads an empty FIFO and never reads two FIFOs in one cycle.
- Counter is CNTW bits; it never exceeds MAX_FLITS and never wraps.

Test Plan:
- Reset, then req=5'b00001, empty=0, tail=1, out_ready=1:
  - grant=00001 at cycle 1, rd_en[0]=1 at cycle 1.
  - out_valid=1 with sel=0 at cycle 2; grant=0 at cycle 2.
- All five inputs requesting 1-flit packets continuously: grants rotate 0,1,2,3,4,0, one packet each, with no input granted twice before all others are served.
- Owner 2 with a 4-flit packet, out_ready low for cycles 3-5:
  - rd_en[2]=0 during the stall; grant held; exactly 4 out_valid pulses with sel=2.
  - Release after the 4th read.
- Owner 1 whose FIFO goes empty after flit 2 of 3: grant held while empty, no rd_en; flit 3 arrives and is read, then IDLE.
- Packet with no tail, MAX_FLITS=16: release after the 16th read; overrun=1 and stays 1; next requester granted.
- rst_n=1 mid-packet after 2 flits: next cycle grant=0, out_valid=0, rd_en=0; after reset, input 0 wins a tie against 3.

Source files
------------

// File: rtl/torus_out_port_arbiter.sv
// Wormhole round-robin arbiter for one torus router output port.
// Holds one input per packet, reads its FIFO while downstream has room, frees on tail.

module torus_oparb_lane (
  input  logic gnt_i,
  input  logic req_i,
  input  logic empty_i,
  input  logic tail_i,
  input  logic rd_ok_i,
  output logic elig_o,
  output logic rd_o,
  output logic tail_rd_o
);
  assign elig_o    = req_i & ~empty_i;
  assign rd_o      = gnt_i & ~empty_i & rd_ok_i;
  assign tail_rd_o = rd_o & tail_i;
endmodule

module torus_out_port_arbiter #(
  parameter int NUM_IN    = 5,
  parameter int SELW      = 3,
  parameter int MAX_FLITS = 16,
  parameter int CNTW      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] empty,
  input  logic [NUM_IN-1:0] tail,
  input  logic              out_ready,
  output logic [NUM_IN-1:0] rd_en,
  output logic [NUM_IN-1:0] grant,
  output logic [SELW-1:0]   sel,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);
  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e            state_q, state_d;
  logic [NUM_IN-1:0] grant_q, grant_d;
  logic [SELW-1:0]   owner_q, owner_d;
  logic [SELW-1:0]   last_q, last_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              vld_q, vld_d;
  logic              ovr_q, ovr_d;

  logic [NUM_IN-1:0] elig, rd_vec, tail_rd;
  logic              rd_ok, any_rd, tail_hit, hit_max;
  logic [CNTW-1:0]   cnt_inc;
  logic              pick_found;
  logic [SELW-1:0]   pick_idx;
  int                cand;

  // A reset cycle never pops a FIFO: that flit would be dropped anyway.
  assign rd_ok = out_ready & ~rst_n;

  for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
    torus_oparb_lane u_lane (
      .gnt_i    (grant_q[i]),
      .req_i    (req[i]),
      .empty_i  (empty[i]),
      .tail_i   (tail[i]),
      .rd_ok_i  (rd_ok),
      .elig_o   (elig[i]),
      .rd_o     (rd_vec[i]),
      .tail_rd_o(tail_rd[i])
    );
  end

  assign any_rd   = |rd_vec;
  assign tail_hit = |tail_rd;
  assign cnt_inc  = cnt_q + CNTW'(1);
  assign hit_max  = (cnt_inc == CNTW'(MAX_FLITS));

  // Rotating search starting just past the last served input.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_IN) cand = cand - NUM_IN;
      if (!pick_found && elig[cand[SELW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[SELW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    vld_d   = any_rd;
    ovr_d   = ovr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_BUSY;
          grant_d = NUM_IN'(1) << pick_idx;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (any_rd) begin
          cnt_d = cnt_inc;
          sel_d = owner_q;
          if (tail_hit || hit_max) begin
            state_d = S_IDLE;
            grant_d = '0;
            last_d  = owner_q;
            cnt_d   = '0;
            if (!tail_hit) ovr_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= SELW'(NUM_IN - 1);
      sel_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rd_en     = rd_vec;
  assign grant     = grant_q;
  assign sel       = sel_q;
  assign out_valid = vld_q;
  assign busy      = (state_q == S_BUSY);
  assign overrun   = ovr_q;
endmodule
